sa_result_drain: RTL and testbench

Output-side collector for the parameterised systolic array (SA). It captures the flattened `Y` result bus on a strobe into a two-deep frame buffer. It then streams the HPE×VPE partial-product results out one element per beat, with row/column tags, over a valid/ready handshake. It is the read-side counterpart to the operand-feed path (`AA`/`BB`) and sits between the SA `Y` port and the result checker / host sink.

---
 rtl/sa_result_drain.sv | 155 +++++++++++++++
 tb/tb_sa_result_drain.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Result drain for the systolic array: double-buffers captured Y frames and streams
// them out one tagged element per beat. Define SA_DRAIN_CKSUM_EN for the per-frame checksum.
module sa_result_drain #(
    parameter int WIDTH = 8,
    parameter int HPE   = 2,
    parameter int VPE   = 2
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [2*WIDTH*HPE*VPE-1:0]          Y,
    input  logic                                Y_VLD,
    output logic [2*WIDTH-1:0]                  OUT_DATA,
    output logic [(HPE > 1 ? $clog2(HPE) : 1)-1:0] OUT_ROW,
    output logic [(VPE > 1 ? $clog2(VPE) : 1)-1:0] OUT_COL,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic                                OUT_LAST,
    output logic                                BUSY,
    output logic                                OVERFLOW
`ifdef SA_DRAIN_CKSUM_EN
    ,
    output logic [2*WIDTH-1:0]                  CKSUM,
    output logic                                CKSUM_VLD
`endif
);

    localparam int DW = 2 * WIDTH;
    localparam int N  = HPE * VPE;
    localparam int RW = (HPE > 1) ? $clog2(HPE) : 1;
    localparam int CW = (VPE > 1) ? $clog2(VPE) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(HPE - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(VPE - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_n;
    logic [1:0]        count, count_n;
    logic              wr_ptr, rd_ptr, rd_ptr_n;
    logic [RW-1:0]     row, row_n;
    logic [CW-1:0]     col, col_n;
    logic [N*DW-1:0]   bank [2];
    logic              xfer, at_last, frame_end, capture_ok, drop;
    logic [DW-1:0]     out_data;
    logic              out_valid, out_last, overflow;

    // Element (r,c) lives at k = r*VPE + c, counted down from the MSB end of the frame.
    function automatic logic [DW-1:0] elem(input logic [N*DW-1:0] f,
                                           input logic [RW-1:0] r,
                                           input logic [CW-1:0] c);
        int k;
        k = int'(r) * VPE + int'(c);
        return f[(N-1-k)*DW +: DW];
    endfunction

    // NOTE: every signal assigned here gets a default first so no latch is inferred;
    // combinational logic uses blocking '=', the registers below use non-blocking '<='.
    always_comb begin
        xfer       = (state == SEND) && OUT_READY;
        at_last    = (row == ROW_MAX) && (col == COL_MAX);
        frame_end  = xfer && at_last;
        // A bank released on this edge can take the incoming frame.
        capture_ok = Y_VLD && ((count != 2'd2) || frame_end);
        drop       = Y_VLD && !capture_ok;
        rd_ptr_n   = rd_ptr ^ frame_end;

        count_n = count;
        case ({capture_ok, frame_end})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase

        row_n = row;
        col_n = col;
        if (xfer) begin
            if (col == COL_MAX) begin
                col_n = '0;
                row_n = at_last ? '0 : row + RW'(1);
            end else begin
                col_n = col + CW'(1);
            end
        end

        state_n = state;
        case (state)
            IDLE:    if (count != 2'd0) state_n = SEND;
            SEND:    if (frame_end && count == 2'd1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: the frame banks carry no reset; they are only read after being written.
    always_ff @(posedge CLK) begin
        if (capture_ok) bank[wr_ptr] <= Y;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            row       <= '0;
            col       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            wr_ptr    <= wr_ptr ^ capture_ok;
            rd_ptr    <= rd_ptr_n;
            row       <= row_n;
            col       <= col_n;
            overflow  <= overflow | drop;
            out_valid <= (state_n == SEND);
            out_last  <= (state_n == SEND) && (row_n == ROW_MAX) && (col_n == COL_MAX);
            // Reloading from unchanged pointers/indices keeps the beat stable under stall.
            if (state_n == SEND) out_data <= elem(bank[rd_ptr_n], row_n, col_n);
        end
    end

    assign OUT_DATA  = out_data;
    assign OUT_ROW   = row;
    assign OUT_COL   = col;
    assign OUT_VALID = out_valid;
    assign OUT_LAST  = out_last;
    assign BUSY      = (count != 2'd0);
    assign OVERFLOW  = overflow;

`ifdef SA_DRAIN_CKSUM_EN
    logic [DW-1:0] acc, acc_sum, cksum;
    logic          cksum_vld;

    // The first beat of a frame restarts the sum instead of adding to the old one.
    assign acc_sum = ((row == '0 && col == '0) ? '0 : acc) + out_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            cksum     <= '0;
            cksum_vld <= 1'b0;
        end else begin
            cksum_vld <= frame_end;
            if (xfer)      acc   <= acc_sum;
            if (frame_end) cksum <= acc_sum;
        end
    end

    assign CKSUM     = cksum;
    assign CKSUM_VLD = cksum_vld;
`endif

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain (WIDTH=8, HPE=VPE=2); checksum checks compile
// in only when SA_DRAIN_CKSUM_EN is defined.
module tb_sa_result_drain;

    logic        CLK;
    logic        RST;
    logic [63:0] Y;
    logic        Y_VLD;
    logic [15:0] OUT_DATA;
    logic [0:0]  OUT_ROW;
    logic [0:0]  OUT_COL;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic        BUSY;
    logic        OVERFLOW;
`ifdef SA_DRAIN_CKSUM_EN
    logic [15:0] CKSUM;
    logic        CKSUM_VLD;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sa_result_drain #(.WIDTH(8), .HPE(2), .VPE(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Y         (Y),
        .Y_VLD     (Y_VLD),
        .OUT_DATA  (OUT_DATA),
        .OUT_ROW   (OUT_ROW),
        .OUT_COL   (OUT_COL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LAST  (OUT_LAST),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW)
`ifdef SA_DRAIN_CKSUM_EN
        ,
        .CKSUM     (CKSUM),
        .CKSUM_VLD (CKSUM_VLD)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {valid, last, row, col, data} of the beat currently presented.
    logic [19:0] obs_beat;
    assign obs_beat = {OUT_VALID, OUT_LAST, OUT_ROW, OUT_COL, OUT_DATA};

    localparam logic [63:0] FA = 64'h0001_0002_0003_0004;
    localparam logic [63:0] F1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] F2 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] F3 = 64'h9999_AAAA_BBBB_CCCC;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [19:0] exp_beat(input logic [63:0] f, input int k);
        logic [15:0] d;
        d = f[(3-k)*16 +: 16];
        return {1'b1, (k == 3), 1'(k / 2), 1'(k % 2), d};
    endfunction

    // Check the presented beat, then let one clock edge pass.
    task automatic beat(input string tag, input logic [63:0] f, input int k);
        check(tag, obs_beat, exp_beat(f, k));
        @(negedge CLK);
    endtask

    task automatic pulse(input logic [63:0] f);
        Y     = f;
        Y_VLD = 1'b1;
        @(negedge CLK);
        Y_VLD = 1'b0;
    endtask

    initial begin
        int idx;
        RST       = 1'b1;
        Y         = '0;
        Y_VLD     = 1'b0;
        OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);

        // Reset state
        check("reset_outs", {OUT_VALID, OUT_LAST, OUT_ROW, OUT_COL, OUT_DATA, BUSY, OVERFLOW}, '0);
`ifdef SA_DRAIN_CKSUM_EN
        check("reset_cksum", {CKSUM_VLD, CKSUM}, '0);
`endif
        RST = 1'b0;
        @(negedge CLK);

        // Single frame, sink always ready
        OUT_READY = 1'b1;
        pulse(FA);
        check("single_lat", {OUT_VALID, BUSY}, 2'b01);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) beat("single_beat", FA, k);
        check("single_end", {OUT_VALID, BUSY, OVERFLOW}, 3'b000);

        // Backpressure: ready pattern 1,0,0 repeating
        OUT_READY = 1'b0;
        pulse(FA);
        @(negedge CLK);
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            check("bp_beat", obs_beat, exp_beat(FA, idx));
            OUT_READY = (c % 3 == 0);
            @(negedge CLK);
            if (OUT_READY) idx++;
        end
        check("bp_end", {OUT_VALID, BUSY}, 2'b00);

        // Two frames buffered, third dropped, then drained with no bubble
        OUT_READY = 1'b0;
        pulse(F1);
        pulse(F2);
        pulse(F3);
        check("ovf_set", {OVERFLOW, BUSY}, 2'b11);
        OUT_READY = 1'b1;
        for (int k = 0; k < 4; k++) beat("ovf_f1", F1, k);
        for (int k = 0; k < 4; k++) beat("ovf_f2", F2, k);
        check("ovf_end", {OUT_VALID, BUSY, OVERFLOW}, 3'b001);

        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("ovf_clear", OVERFLOW, 1'b0);
        @(negedge CLK);

        // Capture collides with the last-beat release of a full buffer
        OUT_READY = 1'b0;
        pulse(F1);
        pulse(F2);
        OUT_READY = 1'b1;
        for (int k = 0; k < 3; k++) beat("col_f1", F1, k);
        Y     = F3;
        Y_VLD = 1'b1;
        beat("col_f1", F1, 3);
        Y_VLD = 1'b0;
        check("col_no_ovf", {OVERFLOW, BUSY}, 2'b01);
        for (int k = 0; k < 4; k++) beat("col_f2", F2, k);
        for (int k = 0; k < 4; k++) beat("col_f3", F3, k);
        check("col_end", {OUT_VALID, BUSY, OVERFLOW}, 3'b000);

        // Reset in the middle of a frame
        pulse(F1);
        @(negedge CLK);
        beat("rst_f1", F1, 0);
        beat("rst_f1", F1, 1);
        RST = 1'b1;
        #1;
        check("rst_async", {OUT_VALID, BUSY, OUT_LAST, OUT_ROW, OUT_COL, OUT_DATA}, '0);
        @(negedge CLK);
        RST = 1'b0;
        pulse(F2);
        check("rst_lat", {OUT_VALID, BUSY}, 2'b01);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) beat("rst_f2", F2, k);

`ifdef SA_DRAIN_CKSUM_EN
        // Per-frame checksum, including 16-bit wraparound
        pulse(FA);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) beat("ck_beat", FA, k);
        check("ck_pulse", {CKSUM_VLD, CKSUM}, {1'b1, 16'h000A});
        @(negedge CLK);
        check("ck_hold", {CKSUM_VLD, CKSUM}, {1'b0, 16'h000A});
        pulse(64'hFFFF_0001_0000_0000);
        @(negedge CLK);
        for (int k = 0; k < 4; k++) beat("ck_beat2", 64'hFFFF_0001_0000_0000, k);
        check("ck_wrap", {CKSUM_VLD, CKSUM}, {1'b1, 16'h0000});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
